wave_sequencer: RTL and testbench
=================================

WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: magnitude counter width; sample width is WIDTH+1.
REQ-002 SHALL have parameter DIV_W, default 4: prescaler divide-value width.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1: when 0, all state holds.
REQ-006 SHALL have port restart, input, 1: synchronous return to start of period.
REQ-007 SHALL have port mode, input, 2: 00 triangle, 01 square, 10 sawtooth, 11 treated as triangle.
REQ-008 SHALL have port div, input, DIV_W: one sample tick every div+1 enabled cycles.
REQ-009 SHALL have port phase, output, 1: 0 = first half of quadrant pair, 1 = second.
REQ-010 SHALL have port sign, output, 1: 0 = positive half-period, 1 = negative.
REQ-011 SHALL have port sample, output, WIDTH+1: unsigned waveform value, midscale 2^WIDTH.
REQ-012 SHALL have port co, output, 1: one-cycle pulse on each quadrant advance.

Function
REQ-013 Prescaler SHALL load div, decrement per enabled cycle, assert internal tick at 0 and reload; div=0 gives tick every enabled cycle; div changes take effect at next reload.
REQ-014 FSM SHALL have states Q0 {phase,sign}=00, Q1 10, Q2 01, Q3 11; order Q0->Q1->Q2->Q3->Q0, advancing only on tick.
REQ-015 Triangle/square: in Q0/Q2 (rising), on tick, if cnt==2^WIDTH-1 advance state and hold cnt, else cnt+1.
REQ-016 Triangle/square: in Q1/Q3 (falling), on tick, if cnt==0 advance state and hold cnt, else cnt-1.
REQ-017 Sawtooth: cnt SHALL increment every tick; on wrap from max to 0 state SHALL advance.
REQ-018 Each quadrant SHALL last 2^WIDTH ticks; full period 4*2^WIDTH ticks in all modes.
REQ-019 co SHALL pulse high for exactly the cycle of the tick that advances state.
REQ-020 Triangle sample SHALL equal sign ? 2^WIDTH-cnt : 2^WIDTH+cnt.
REQ-021 Square sample SHALL equal sign ? 0 : 2^(WIDTH+1)-1.
REQ-022 Sawtooth sample SHALL equal {sign, phase, cnt[WIDTH-1:1]}.
REQ-023 mode SHALL be latched into an internal register only at the Q3->Q0 advance and on restart; mid-period mode changes are ignored until then.
REQ-024 restart SHALL set state Q0, cnt 0, reload prescaler, latch mode; restart wins over simultaneous tick; restart acts even when en=0.

Reset
REQ-025 On rst low SHALL asynchronously force state Q0, cnt 0, prescaler loaded with 0, latched mode triangle, co 0, phase 0, sign 0, sample 2^WIDTH.
REQ-026 Release of rst SHALL be followed by normal operation on the next rising clk with no spurious co.

Configuration
REQ-027 With WAVE_SEQ_REG_OUT_EN defined, sample, phase, sign and co SHALL be registered, adding one cycle latency; reset values unchanged.
REQ-028 Without WAVE_SEQ_REG_OUT_EN, outputs SHALL be combinational from state/cnt/latched mode, zero added latency.

Structure
REQ-029 Package wave_seq_pkg SHALL hold the state enum (Q0..Q3) and mode constants (MODE_TRI, MODE_SQR, MODE_SAW).
REQ-030 Prescaler SHALL be sub-module wave_seq_prescaler (inputs clk, rst, en, restart, div; output tick).

Verification (WIDTH=4, div=0, en=1, macro off unless stated)
REQ-031 Triangle from reset -> sample 16..31, 31..16, 16..1, 1..16, co at cycles 16/32/48/64, period 64 cycles.
REQ-032 Square -> sample 31 for 32 cycles, 0 for 32 cycles; sawtooth -> sample 0..31 step 1 per 2 ticks, monotonic, wraps at 64.
REQ-033 div=3 triangle -> each sample value held 4 cycles; period 256 cycles; co pulse width 1 cycle.
REQ-034 Mode switched triangle->square at cycle 20 -> triangle continues to cycle 64, square from cycle 64; restart at cycle 20 -> square immediately, sample 31.
REQ-035 rst low at cycle 40 mid-Q2 -> immediate sample 16, phase 0, sign 0, co 0; en=0 for 10 cycles -> all outputs frozen.
REQ-036 Macro defined -> every output sequence of REQ-031 delayed by exactly one cycle.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// Shared types for the wave sequencer: quadrant encoding, mode constants and helpers.
package wave_seq_pkg;

  // Encoding is {phase, sign} so the outputs fall straight out of the state bits.
  typedef enum logic [1:0] {
    Q0 = 2'b00,
    Q1 = 2'b10,
    Q2 = 2'b01,
    Q3 = 2'b11
  } quad_e;

  localparam logic [1:0] MODE_TRI = 2'b00;
  localparam logic [1:0] MODE_SQR = 2'b01;
  localparam logic [1:0] MODE_SAW = 2'b10;

  function automatic quad_e next_quad(input quad_e q);
    quad_e n;
    case (q)
      Q0:      n = Q1;
      Q1:      n = Q2;
      Q2:      n = Q3;
      default: n = Q0;
    endcase
    return n;
  endfunction

  // The unused encoding 11 behaves as triangle, so it is folded at latch time.
  function automatic logic [1:0] sanitize_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_TRI : m;
  endfunction

endpackage

// File: rtl/wave_seq_prescaler.sv
// Sample-rate prescaler: one tick every div+1 enabled cycles; div is sampled on reload.
module wave_seq_prescaler #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = div;
    end else if (en) begin
      if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = div;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Quadrant-based triangle/square/sawtooth generator with prescaled sample rate.
// Define WAVE_SEQ_REG_OUT_EN to register sample/phase/sign/co (one cycle of latency).
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic             phase,
  output logic             sign,
  output logic [WIDTH:0]   sample,
  output logic             co
);

  localparam logic [WIDTH-1:0] CntMax = '1;
  localparam logic [WIDTH:0]   Mid    = {1'b1, {WIDTH{1'b0}}};

  quad_e            state_d, state_q;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic [1:0]       mode_d, mode_q;
  logic             tick;
  logic             adv;

  logic             phase_c, sign_c, co_c;
  logic [WIDTH:0]   sample_c;

  wave_seq_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(restart),
    .div    (div),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    adv     = 1'b0;
    if (restart) begin
      state_d = Q0;
      cnt_d   = '0;
      mode_d  = sanitize_mode(mode);
    end else if (tick) begin
      if (mode_q == MODE_SAW) begin
        cnt_d = cnt_q + WIDTH'(1);
        adv   = (cnt_q == CntMax);
      end else if (state_q == Q0 || state_q == Q2) begin
        if (cnt_q == CntMax) begin
          adv = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          adv = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      if (adv) begin
        state_d = next_quad(state_q);
        // New mode only takes hold at a period boundary so a waveform is never torn.
        if (state_q == Q3) begin
          mode_d = sanitize_mode(mode);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= Q0;
      cnt_q   <= '0;
      mode_q  <= MODE_TRI;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    phase_c = state_q[1];
    sign_c  = state_q[0];
    co_c    = adv;
    case (mode_q)
      MODE_SQR: sample_c = sign_c ? '0 : '1;
      MODE_SAW: sample_c = {sign_c, phase_c, cnt_q[WIDTH-1:1]};
      default:  sample_c = sign_c ? (Mid - {1'b0, cnt_q}) : (Mid + {1'b0, cnt_q});
    endcase
  end

`ifdef WAVE_SEQ_REG_OUT_EN
  logic           phase_q, sign_q, co_q;
  logic [WIDTH:0] sample_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= 1'b0;
      sign_q   <= 1'b0;
      co_q     <= 1'b0;
      sample_q <= Mid;
    end else begin
      phase_q  <= phase_c;
      sign_q   <= sign_c;
      co_q     <= co_c;
      sample_q <= sample_c;
    end
  end

  assign phase  = phase_q;
  assign sign   = sign_q;
  assign co     = co_q;
  assign sample = sample_q;
`else
  assign phase  = phase_c;
  assign sign   = sign_c;
  assign co     = co_c;
  assign sample = sample_c;
`endif

endmodule

// File: tb/tb_wave_sequencer.sv
// Randomized bench for wave_sequencer (WIDTH=4) against a period-position reference model.
module tb_wave_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DIV_W = 4;
  localparam int N = 1 << WIDTH;
  localparam int P = 4 * N;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             restart = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [DIV_W-1:0] div = '0;
  logic             phase, sign, co;
  logic [WIDTH:0]   sample;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position in period (ticks since Q0 start), prescaler count, latched mode.
  int m_k, m_presc, m_mode;
  int p_s, p_ph, p_sg, p_co;

  wave_sequencer #(
    .WIDTH(WIDTH),
    .DIV_W(DIV_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(restart),
    .mode   (mode),
    .div    (div),
    .phase  (phase),
    .sign   (sign),
    .sample (sample),
    .co     (co)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, act, exp);
    end
  endtask

  function automatic int eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? 0 : int'(m);
  endfunction

  task automatic model_reset();
    m_k = 0; m_presc = 0; m_mode = 0;
    p_s = N; p_ph = 0; p_sg = 0; p_co = 0;
  endtask

  task automatic calc_exp(output int s, output int ph, output int sg, output int c);
    int q, p, cv;
    q  = m_k / N;
    p  = m_k % N;
    ph = q % 2;
    sg = q / 2;
    case (m_mode)
      1:       s = (q < 2) ? (2 * N - 1) : 0;
      2:       s = m_k / 2;
      default: begin
        cv = (q % 2 == 0) ? p : (N - 1 - p);
        s  = (q < 2) ? (N + cv) : (N - cv);
      end
    endcase
    c = (en && !restart && m_presc == 0 && p == N - 1) ? 1 : 0;
  endtask

  task automatic model_step();
    if (restart) begin
      m_k = 0; m_presc = int'(div); m_mode = eff_mode(mode);
    end else if (en) begin
      if (m_presc == 0) begin
        m_presc = int'(div);
        m_k = (m_k + 1) % P;
        if (m_k == 0) m_mode = eff_mode(mode);
      end else begin
        m_presc--;
      end
    end
  endtask

  task automatic check_outputs();
    int es, eph, esg, eco;
    calc_exp(es, eph, esg, eco);
`ifdef WAVE_SEQ_REG_OUT_EN
    check_eq("sample", int'(sample), p_s);
    check_eq("phase", int'(phase), p_ph);
    check_eq("sign", int'(sign), p_sg);
    check_eq("co", int'(co), p_co);
`else
    check_eq("sample", int'(sample), es);
    check_eq("phase", int'(phase), eph);
    check_eq("sign", int'(sign), esg);
    check_eq("co", int'(co), eco);
`endif
    p_s = es; p_ph = eph; p_sg = esg; p_co = eco;
  endtask

  // seg: 0 = triangle free-run, 1 = square, 2 = sawtooth, 3 = fully random
  task automatic run_cycles(input int n, input int seg);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (seg < 3) begin
        rst = 1'b1; en = 1'b1; restart = 1'b0; div = '0; mode = 2'(seg);
      end else begin
        rst     = ($urandom_range(0, 399) != 0);
        en      = ($urandom_range(0, 7) != 0);
        restart = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 31) == 0) div = DIV_W'($urandom_range(0, 3));
      end
      #1;
      if (!rst) begin
        model_reset();
        check_eq("rst_sample", int'(sample), N);
        check_eq("rst_phase", int'(phase), 0);
        check_eq("rst_sign", int'(sign), 0);
        check_eq("rst_co", int'(co), 0);
      end else begin
        check_outputs();
        model_step();
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_sample", int'(sample), N);
    check_eq("rst_phase", int'(phase), 0);
    check_eq("rst_sign", int'(sign), 0);
    check_eq("rst_co", int'(co), 0);
    run_cycles(2 * P + 10, 0);
    run_cycles(2 * P, 1);
    run_cycles(2 * P, 2);
    run_cycles(6000, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
